seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Output-side counterpart of the switch input-conditioning stage: it drives the board's 4-digit multiplexed 7-segment display pins instead of conditioning inputs from the board.
- Takes a 16-bit hex value plus per-digit decimal-point and enable masks through a load strobe, double-buffered.
- Scans the digits with an anti-ghosting blank gap before each digit and registers all pin outputs.

Parameters:
- Simulacion, 0: 1 selects the short simulation timing.
- CLK_HZ, 10_000_000: system clock frequency in Hz.
- REFRESH_HZ, 1000: per-digit refresh rate on hardware.
- Derived: DIGIT_TICKS = Simulacion ? 4 : CLK_HZ/(REFRESH_HZ*4).
- Derived: BLANK_TICKS = Simulacion ? 1 : DIGIT_TICKS/16.
- Elaboration error if DIGIT_TICKS < BLANK_TICKS+1 or BLANK_TICKS < 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  16  four hex nibbles; digit i = value[4i+3:4i].
- dp_in  in  4  decimal point per digit, 1 = lit.
- digit_en  in  4  per-digit enable, 1 = shown.
- lz_blank  in  1  leading-zero blanking enable. Sampled live, not buffered.
- load  in  1  one-cycle strobe that captures value, dp_in and digit_en.
- AN  out  4  digit anodes, active-low.
- SEG  out  7  segments, active-low; SEG[6]=g … SEG[0]=a.
- DP  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at frame boundary.
- load_ack  out  1  one-cycle pulse when pending data becomes displayed.

Behaviour:
- Reset (reset=0, async):
  - AN=4'hF, SEG=7'h7F, DP=1, frame_tick=0, load_ack=0.
  - Internal state: idx=0, cnt=0, shadow regs=0, pending regs=0, pending flag=0.
- Scan counters:
  - cnt counts 0..DIGIT_TICKS-1, then wraps to 0 and idx increments mod 4.
  - One slot = DIGIT_TICKS cycles. One frame = 4 slots.
- Slot phases:
  - BLANK while cnt < BLANK_TICKS: AN=4'hF, SEG=7'h7F, DP=1.
  - DRIVE otherwise: AN has only bit idx low, if the digit is visible.
- Visibility of digit idx:
  - Requires shadow_en[idx]=1.
  - If lz_blank=1, also requires idx==0 or idx <= index of the most significant nonzero shadow nibble.
  - Digit 0 is never blanked by lz_blank.
  - Invisible digit: AN=4'hF, SEG=7'h7F, DP=1 for the whole slot.
- Segment decode (active-low hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78.
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
  - DP = ~shadow_dp[idx].
- Latency:
  - All pin outputs are registered.
  - Pins at edge k reflect the cnt/idx/shadow values present during cycle k-1, i.e. one cycle of latency.
- Load handshake:
  - On a clock edge with load=1, value, dp_in and digit_en are copied into the pending regs and pending flag is set to 1.
  - A load while pending=1 overwrites the pending regs (last wins). There is no backpressure.
- Frame boundary (cycle with idx=3 and cnt=DIGIT_TICKS-1):
  - frame_tick=1 on the next edge.
  - If pending=1: shadow <= pending on that edge, load_ack=1 on the next edge, pending flag cleared.
  - If load=1 in the boundary cycle: the old pending data goes to shadow, the new inputs go to pending, and the flag stays 1. load_ack still pulses. The new data is acked at the following frame.
- Other rules:
  - Shadow never changes mid-frame, so no torn display.
  - Reset asserted mid-frame restarts at idx=0, cnt=0 with shadow=0 and discards pending data.
  - The first frame after reset shows 0000 only on enabled digits; shadow_en=0, so all digits are dark until the first load is acked.

Test Plan (Simulacion=1: 4-cycle slot, 1 blank cycle, 16-cycle frame):
1. Reset release with no load → AN=F, SEG=7F, DP=1 for 32 cycles; frame_tick pulses every 16 cycles. Then assert reset mid-slot → AN=F immediately (async).
2. load value=16'h12AF, dp=4'b0100, en=4'hF → load_ack one cycle after the next frame boundary. Next frame, per slot:
   - digit0: AN=1110, SEG=0E.
   - digit1: AN=1101, SEG=08.
   - digit2: AN=1011, SEG=24, DP=0.
   - digit3: AN=0111, SEG=79.
   - Each slot preceded by exactly one all-blank cycle.
3. lz_blank=1, value=16'h0050, en=F → digits 0–1 driven (SEG 40, 12); digits 2–3 keep AN=F. Then value=0000 → only digit0 driven (SEG=40).
4. Two loads in one frame (16'h1111, then 16'h2222) → a single load_ack; display shows 2222 and never 1111.
5. load 16'h3333 exactly in the boundary cycle while 16'h4444 is pending → next frame shows 4444 with load_ack; the following frame shows 3333 with a second load_ack.
6. en=4'b0101 → AN never goes low for digits 1 and 3; no AN value ever has two zero bits.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment driver: double-buffered load, blank-gap scanning,
// optional leading-zero suppression, all pins registered.
module seg7_scan_driver #(
    parameter int Simulacion = 0,
    parameter int CLK_HZ     = 10_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    input  logic        load,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_tick,
    output logic        load_ack
);

    localparam int DIGIT_TICKS = (Simulacion != 0) ? 4 : CLK_HZ / (REFRESH_HZ * 4);
    localparam int BLANK_TICKS = (Simulacion != 0) ? 1 : DIGIT_TICKS / 16;
    localparam int CNT_W       = $clog2(DIGIT_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_TICKS);

    generate
        if (DIGIT_TICKS < BLANK_TICKS + 1 || BLANK_TICKS < 1) begin : g_bad_timing
            $error("seg7_scan_driver: slot too short for the blank gap");
        end
    endgenerate

    // Active-low hex glyphs, SEG[6]=g .. SEG[0]=a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic [15:0]      shadow_val_r, pend_val_r;
    logic [3:0]       shadow_dp_r, shadow_en_r, pend_dp_r, pend_en_r;
    logic             pend_r;

    logic             boundary_s;
    logic [1:0]       msnz_s;
    logic [3:0]       cur_nib_s;
    logic             visible_s;
    logic             drive_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic             dp_s;

    // Frame boundary and index of the most significant nonzero displayed nibble.
    always_comb begin
        boundary_s = (idx_r == 2'd3) && (cnt_r == CNT_LAST);
        msnz_s     = 2'd0;
        if (shadow_val_r[15:12] != 4'h0) begin
            msnz_s = 2'd3;
        end else if (shadow_val_r[11:8] != 4'h0) begin
            msnz_s = 2'd2;
        end else if (shadow_val_r[7:4] != 4'h0) begin
            msnz_s = 2'd1;
        end else begin
            msnz_s = 2'd0;
        end
    end

    // Next pin values for the current slot; digit 0 is exempt from zero suppression.
    always_comb begin
        case (idx_r)
            2'd0:    cur_nib_s = shadow_val_r[3:0];
            2'd1:    cur_nib_s = shadow_val_r[7:4];
            2'd2:    cur_nib_s = shadow_val_r[11:8];
            2'd3:    cur_nib_s = shadow_val_r[15:12];
            default: cur_nib_s = 4'h0;
        endcase
        visible_s = shadow_en_r[idx_r] &&
                    (!lz_blank || (idx_r == 2'd0) || (idx_r <= msnz_s));
        drive_s   = (cnt_r >= CNT_BLANK) && visible_s;
        if (drive_s) begin
            an_s  = ~(4'b0001 << idx_r);
            seg_s = hex_to_seg(cur_nib_s);
            dp_s  = ~shadow_dp_r[idx_r];
        end else begin
            an_s  = 4'hF;
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end
    end

    // Slot tick counter and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Pending/shadow double buffer; shadow only moves at a frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_val_r <= 16'h0000;
            shadow_dp_r  <= 4'h0;
            shadow_en_r  <= 4'h0;
            pend_val_r   <= 16'h0000;
            pend_dp_r    <= 4'h0;
            pend_en_r    <= 4'h0;
            pend_r       <= 1'b0;
        end else begin
            if (boundary_s && pend_r) begin
                shadow_val_r <= pend_val_r;
                shadow_dp_r  <= pend_dp_r;
                shadow_en_r  <= pend_en_r;
            end
            if (load) begin
                pend_val_r <= value;
                pend_dp_r  <= dp_in;
                pend_en_r  <= digit_en;
                pend_r     <= 1'b1;
            end else if (boundary_s) begin
                pend_r     <= 1'b0;
            end
        end
    end

    // Registered pin outputs and handshake pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN         <= 4'hF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            AN         <= an_s;
            SEG        <= seg_s;
            DP         <= dp_s;
            frame_tick <= boundary_s;
            load_ack   <= boundary_s && pend_r;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver in short simulation timing: directed scenarios followed
// by random traffic, every cycle checked against a cycle-count based display model.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_tick;
    logic        load_ack;

    seg7_scan_driver #(.Simulacion(1), .CLK_HZ(10_000_000), .REFRESH_HZ(1000)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .load(load), .AN(AN), .SEG(SEG), .DP(DP),
        .frame_tick(frame_tick), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: cycles since reset release plus displayed/queued frame contents.
    int          cyc;
    logic [15:0] sh_val, pd_val;
    logic [3:0]  sh_dp, sh_en, pd_dp, pd_en;
    bit          pd;

    int ack_seen;
    bit seen_one;
    bit multi_zero;
    bit odd_lit;

    task automatic model_clear();
        cyc = 0; sh_val = 16'h0; sh_dp = 4'h0; sh_en = 4'h0;
        pd_val = 16'h0; pd_dp = 4'h0; pd_en = 4'h0; pd = 1'b0;
    endtask

    task automatic check_vec(input string tag, input logic [13:0] obs, input logic [13:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        int idx, cn;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        bit         vis, bnd, ack_e;
        idx   = (cyc / 4) % 4;
        cn    = cyc % 4;
        vis   = sh_en[idx] && (!lz_blank || idx == 0 || ((sh_val >> (4 * idx)) != 16'h0));
        an_e  = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
        if (cn >= 1 && vis) begin
            an_e  = ~(4'b0001 << idx);
            seg_e = seg_tbl[sh_val[4*idx +: 4]];
            dp_e  = ~sh_dp[idx];
        end
        bnd   = (cyc % 16) == 15;
        ack_e = bnd && pd;
        if (bnd && pd) begin
            sh_val = pd_val; sh_dp = pd_dp; sh_en = pd_en; pd = 1'b0;
        end
        if (load) begin
            pd_val = value; pd_dp = dp_in; pd_en = digit_en; pd = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
        check_vec("pins", {AN, SEG, DP, frame_tick, load_ack}, {an_e, seg_e, dp_e, bnd, ack_e});
        if (load_ack) ack_seen++;
        if (SEG == 7'h79) seen_one = 1'b1;
        if ($countones(~AN) > 1) multi_zero = 1'b1;
        if (!AN[1] || !AN[3]) odd_lit = 1'b1;
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value = v; dp_in = d; digit_en = e; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic run_to_boundary();
        while ((cyc % 16) != 15) step();
    endtask

    initial begin
        model_clear();
        ack_seen = 0; seen_one = 1'b0; multi_zero = 1'b0; odd_lit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_state", {AN, SEG, DP, frame_tick, load_ack}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        reset = 1'b1;

        // 1: idle display dark, frame ticks, then async reset mid-slot
        repeat (38) step();
        reset = 1'b0;
        #1;
        check_vec("async_reset", {AN, SEG, DP, frame_tick, load_ack}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();

        // 2: basic load 12AF with DP on digit 2
        ack_seen = 0;
        pulse_load(16'h12AF, 4'b0100, 4'hF);
        repeat (40) step();
        check_int("ack_12AF", ack_seen, 1);

        // 3: leading-zero blanking
        lz_blank = 1'b1;
        pulse_load(16'h0050, 4'h0, 4'hF);
        repeat (36) step();
        pulse_load(16'h0000, 4'h0, 4'hF);
        repeat (36) step();
        lz_blank = 1'b0;

        // 4: two loads in one frame, last wins
        run_to_boundary();
        step();
        ack_seen = 0; seen_one = 1'b0;
        pulse_load(16'h1111, 4'h0, 4'hF);
        repeat (3) step();
        pulse_load(16'h2222, 4'h0, 4'hF);
        repeat (40) step();
        check_int("single_ack", ack_seen, 1);
        check_int("never_1111", int'(seen_one), 0);

        // 5: load in the boundary cycle while data is pending
        ack_seen = 0;
        pulse_load(16'h4444, 4'h0, 4'hF);
        run_to_boundary();
        value = 16'h3333; load = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();
        check_int("boundary_acks", ack_seen, 2);

        // 6: sparse enable mask
        pulse_load(16'($urandom), 4'($urandom), 4'b0101);
        run_to_boundary();
        step();
        odd_lit = 1'b0;
        repeat (32) step();
        check_int("disabled_dark", int'(odd_lit), 0);

        // random traffic
        repeat (400) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            lz_blank = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 5) == 0);
            step();
            load     = 1'b0;
        end
        check_int("one_anode_max", int'(multi_zero), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
